// File: rtl/core_regfile.sv
// Register file: 254 general registers with pc_in/ra_in mapped at the two end addresses
// and a self-clearing sequence. Optional same-cycle write-to-read bypass via REGFILE_BYPASS_EN.
module core_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_rs1,
  input  logic [ADDR_W-1:0] addr_rs2,
  output logic [DATA_W-1:0] data_rs1,
  output logic [DATA_W-1:0] data_rs2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr_rd,
  input  logic [DATA_W-1:0] data_rd,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] ra_in,
  input  logic              clr_req,
  output logic              ready,
  output logic              wr_err
);

  localparam int unsigned     NUM_REGS  = (1 << ADDR_W) - 2;
  localparam logic [ADDR_W-1:0] PC_ADDR   = '0;
  localparam logic [ADDR_W-1:0] RA_ADDR   = '1;
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic                wr_err_d;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                wr_acc_c;
  logic                gen_addr_c;

  logic [DATA_W-1:0]   mem [1:NUM_REGS];

  assign gen_addr_c = (addr_rd != PC_ADDR) && (addr_rd != RA_ADDR);
  assign ready      = (state_q == IDLE);

  // State, clear counter and error pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= FIRST_IDX;
      wr_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      wr_err    <= wr_err_d;
    end
  end

  // Next-state, clear sweep and write arbitration
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wr_err_d  = 1'b0;
    wr_acc_c  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_rd;
    mem_wdata = data_rd;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        wr_err_d  = wr_en;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = IDLE;
          clr_idx_d = FIRST_IDX;
        end else begin
          clr_idx_d = clr_idx_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (wr_en) begin
          if (gen_addr_c) begin
            wr_acc_c = 1'b1;
            mem_we   = 1'b1;
          end else begin
            wr_err_d = 1'b1;
          end
        end
        // A write in the same cycle still commits; the sweep then zeroes it
        if (clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = FIRST_IDX;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_idx_d = FIRST_IDX;
      end
    endcase
  end

  // Storage has no reset; the clear sweep initialises it
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Read port 1
  always_comb begin
    data_rs1 = '0;
    if (addr_rs1 == PC_ADDR)      data_rs1 = pc_in;
    else if (addr_rs1 == RA_ADDR) data_rs1 = ra_in;
    else if (ready)               data_rs1 = mem[addr_rs1];
`ifdef REGFILE_BYPASS_EN
    if (wr_acc_c && (addr_rs1 == addr_rd)) data_rs1 = data_rd;
`endif
  end

  // Read port 2
  always_comb begin
    data_rs2 = '0;
    if (addr_rs2 == PC_ADDR)      data_rs2 = pc_in;
    else if (addr_rs2 == RA_ADDR) data_rs2 = ra_in;
    else if (ready)               data_rs2 = mem[addr_rs2];
`ifdef REGFILE_BYPASS_EN
    if (wr_acc_c && (addr_rs2 == addr_rd)) data_rs2 = data_rd;
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_wr_acc;
  assign unused_wr_acc = wr_acc_c;
`endif

endmodule

// File: tb/tb_core_regfile.sv
// Scoreboard bench for core_regfile: stimulus queues expectations, a negedge monitor checks them.
module tb_core_regfile;

  logic        clk;
  logic        rst;
  logic [7:0]  addr_rs1, addr_rs2, addr_rd;
  logic [31:0] data_rs1, data_rs2, data_rd, pc_in, ra_in;
  logic        wr_en, clr_req, ready, wr_err;

  int checks   = 0;
  int failures = 0;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] SAME_CYC = 32'hDEADBEEF;
`else
  localparam logic [31:0] SAME_CYC = 32'h0000_0000;
`endif

  typedef struct {
    string       name;
    bit          is_data;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        rdy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  core_regfile #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
    .data_rs1(data_rs1), .data_rs2(data_rs2),
    .wr_en(wr_en), .addr_rd(addr_rd), .data_rd(data_rd),
    .pc_in(pc_in), .ra_in(ra_in), .clr_req(clr_req),
    .ready(ready), .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Monitor: compare DUT outputs against every queued expectation at the falling edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (e.is_data) begin
        if (data_rs1 !== e.d1 || data_rs2 !== e.d2) begin
          failures++;
          $display("FAIL %s: got rs1=%h rs2=%h, required rs1=%h rs2=%h",
                   e.name, data_rs1, data_rs2, e.d1, e.d2);
        end
      end else begin
        if (ready !== e.rdy || wr_err !== e.err) begin
          failures++;
          $display("FAIL %s: got ready=%b wr_err=%b, required ready=%b wr_err=%b",
                   e.name, ready, wr_err, e.rdy, e.err);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rd(input string n, input logic [7:0] a1, input logic [7:0] a2,
                        input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    addr_rs1 = a1;
    addr_rs2 = a2;
    e.name = n; e.is_data = 1'b1; e.d1 = e1; e.d2 = e2; e.rdy = 1'b0; e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic exp_fl(input string n, input logic r, input logic er);
    exp_t e;
    e.name = n; e.is_data = 1'b0; e.d1 = '0; e.d2 = '0; e.rdy = r; e.err = er;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr_rd = a; data_rd = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
    addr_rs1 = 8'h00; addr_rs2 = 8'h00; addr_rd = 8'h00; data_rd = 32'h0;
    pc_in = 32'h0000_0040; ra_in = 32'h0000_0020;

    // Held in reset
    step(); step();
    exp_fl("rst_state", 1'b0, 1'b0);
    exp_rd("rst_read", 8'h10, 8'h00, 32'h0, 32'h0000_0040);
    step();

    // Release, 254-cycle clear, dropped write at clear cycle 10
    rst = 1'b1;
    exp_fl("rel_c0", 1'b0, 1'b0);
    for (int k = 1; k <= 254; k++) begin
      step();
      if (k == 9)  begin wr_en = 1'b1; addr_rd = 8'h05; data_rd = 32'h0000_1234; end
      if (k == 10) wr_en = 1'b0;
      exp_fl($sformatf("rel_c%0d", k), (k == 254), (k == 10));
      if (k == 50) exp_rd("clr_map_read", 8'hFF, 8'h00, 32'h0000_0020, 32'h0000_0040);
    end
    exp_rd("post_clr_ends", 8'h01, 8'hFE, 32'h0, 32'h0);
    step();
    exp_rd("dropped_05", 8'h05, 8'h80, 32'h0, 32'h0);
    step();

    // Write then same-cycle and next-cycle reads
    wr_en = 1'b1; addr_rd = 8'h10; data_rd = 32'hDEADBEEF;
    exp_rd("same_cycle_10", 8'h10, 8'h10, SAME_CYC, SAME_CYC);
    step();
    wr_en = 1'b0;
    exp_rd("next_cycle_10", 8'h10, 8'h10, 32'hDEADBEEF, 32'hDEADBEEF);
    exp_fl("good_wr_no_err", 1'b1, 1'b0);
    step();

    // Writes to the mapped addresses are dropped with an error pulse
    wr_en = 1'b1; addr_rd = 8'h00; data_rd = 32'd5;
    exp_rd("pc_ra_read", 8'h00, 8'hFF, 32'h0000_0040, 32'h0000_0020);
    step();
    addr_rd = 8'hFF; data_rd = 32'd7;
    exp_fl("err_after_pc_wr", 1'b1, 1'b1);
    step();
    wr_en = 1'b0;
    exp_fl("err_after_ra_wr", 1'b1, 1'b1);
    exp_rd("pc_ra_unchanged", 8'hFF, 8'h00, 32'h0000_0020, 32'h0000_0040);
    step();
    exp_fl("err_cleared", 1'b1, 1'b0);
    pc_in = 32'h1000_0004;
    exp_rd("pc_live", 8'h00, 8'h10, 32'h1000_0004, 32'hDEADBEEF);
    step();
    pc_in = 32'h0000_0040;

    // Distinct data patterns and overwrite
    wr(8'h01, 32'h1234_5678);
    wr(8'hFE, 32'h5555_AAAA);
    wr(8'h20, 32'h0000_00AA);
    exp_rd("pat_01_fe", 8'h01, 8'hFE, 32'h1234_5678, 32'h5555_AAAA);
    step();
    wr(8'h01, 32'hCAFE_F00D);
    exp_rd("pat_01_20", 8'h01, 8'h20, 32'hCAFE_F00D, 32'h0000_00AA);
    step();

    // clr_req with a same-cycle write; second request during clear is ignored
    wr_en = 1'b1; addr_rd = 8'h30; data_rd = 32'h0000_0077; clr_req = 1'b1;
    exp_fl("clr_entry", 1'b1, 1'b0);
    step();
    for (int j = 1; j <= 255; j++) begin
      if (j == 1)  begin clr_req = 1'b0; wr_en = 1'b0; end
      if (j == 51) clr_req = 1'b1;
      if (j == 52) clr_req = 1'b0;
      exp_fl($sformatf("clr_c%0d", j), (j == 255), 1'b0);
      if (j == 20) exp_rd("clr_gen_zero", 8'h20, 8'h10, 32'h0, 32'h0);
      if (j < 255) step();
    end
    step();
    exp_rd("clr_20_30", 8'h20, 8'h30, 32'h0, 32'h0);
    step();
    exp_rd("clr_10_01", 8'h10, 8'h01, 32'h0, 32'h0);
    step();

    // Reset during a write, then again at clear cycle 100
    wr(8'h40, 32'h0000_0099);
    wr_en = 1'b1; addr_rd = 8'h40; data_rd = 32'hBAD0_BAD0; rst = 1'b0;
    exp_fl("rst_mid_wr", 1'b0, 1'b0);
    step();
    wr_en = 1'b0;
    step();
    rst = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      exp_fl($sformatf("pre_abort_c%0d", k), 1'b0, 1'b0);
    end
    rst = 1'b0;
    exp_fl("abort_held", 1'b0, 1'b0);
    step(); step();
    rst = 1'b1;
    for (int k = 1; k <= 254; k++) begin
      step();
      exp_fl($sformatf("restart_c%0d", k), (k == 254), 1'b0);
    end
    exp_rd("restart_40", 8'h40, 8'h01, 32'h0, 32'h0);
    step();

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_regfile.md
CORE_REGFILE -- requirements
Module: core_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning register address width (256 entries).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port addr_rs1  input  8  read port 1 address from core.
REQ-006 SHALL have port addr_rs2  input  8  read port 2 address from core.
REQ-007 SHALL have port data_rs1  output  32  read port 1 data to core.
REQ-008 SHALL have port data_rs2  output  32  read port 2 data to core.
REQ-009 SHALL have port wr_en  input  1  write request qualifier.
REQ-010 SHALL have port addr_rd  input  8  write address from core.
REQ-011 SHALL have port data_rd  input  32  write data from core.
REQ-012 SHALL have port pc_in  input  32  current programCounter, mapped at address 0x00.
REQ-013 SHALL have port ra_in  input  32  current addressReg (return address), mapped at address 0xFF.
REQ-014 SHALL have port clr_req  input  1  request full clear of general registers.
REQ-015 SHALL have port ready  output  1  1 = writes accepted, general reads valid.
REQ-016 SHALL have port wr_err  output  1  registered one-cycle pulse: write request dropped.

Function
REQ-017 SHALL hold 254 general 32-bit registers, addresses 0x01-0xFE.
REQ-018 Reads SHALL be combinational: address 0x00 -> pc_in, 0xFF -> ra_in, else stored value; while ready=0, general-address reads return 0.
REQ-019 Write SHALL commit on rising edge when wr_en=1, ready=1, addr_rd in 0x01-0xFE; visible on reads from the next cycle.
REQ-020 Write with wr_en=1 and (addr_rd=0x00, addr_rd=0xFF, or ready=0) SHALL be dropped, storage unchanged, wr_err=1 for exactly the following cycle.
REQ-021 Both read ports SHALL serve the same address simultaneously with identical data.
REQ-022 FSM SHALL have states CLEAR and IDLE; ready=1 only in IDLE.
REQ-023 CLEAR: 8-bit counter clr_idx starts at 0x01, writes 0 to mem[clr_idx] each cycle, increments; after writing 0xFE go to IDLE next cycle (254 clear cycles, ready=1 on cycle 255).
REQ-024 IDLE: clr_req=1 SHALL enter CLEAR next cycle with clr_idx=0x01; a write presented in that same cycle SHALL commit (ready still 1) and then be cleared.
REQ-025 clr_req during CLEAR SHALL be ignored; clear is not restarted.
REQ-026 clr_idx SHALL never wrap; 0x00 and 0xFF are never written.

Reset
REQ-027 While rst=0: state=CLEAR, clr_idx=0x01, ready=0, wr_err=0; storage not reset directly.
REQ-028 After rst deasserts, clear sequence per REQ-023 SHALL run from the first rising edge.
REQ-029 rst asserted mid-clear or mid-write SHALL abort immediately and restart clear from 0x01 on release; partial write discarded.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN: when defined, a read whose address equals an accepted same-cycle write address (REQ-019) SHALL return data_rd combinationally; when undefined, it returns the old stored value until the next cycle.

Verification
REQ-031 Reset release, wait: ready=0 for 254 cycles then 1; read any 0x01-0xFE -> 0x00000000.
REQ-032 Write 0x10 <= 0xDEADBEEF, next cycle addr_rs1=addr_rs2=0x10 -> both 0xDEADBEEF; same-cycle read -> 0xDEADBEEF with REGFILE_BYPASS_EN, 0x00000000 without.
REQ-033 pc_in=0x00000040, ra_in=0x00000020, write 0x00<=5 and 0xFF<=7 -> reads 0x40/0x20, wr_err pulses each cycle after.
REQ-034 Write during CLEAR (cycle 10 after reset) 0x05<=0x1234 -> dropped, wr_err=1 next cycle, 0x05 reads 0 after ready.
REQ-035 In IDLE with 0x20=0xAA, pulse clr_req, pulse again 50 cycles later -> ready low exactly 254 cycles, 0x20 reads 0.
REQ-036 Assert rst at clear cycle 100, release -> full 254-cycle clear restarts, ready rises 254 cycles after release.
